// File: rtl/life_tracker.sv
// Game-state controller: tracks lives, score and the post-hit grace window,
// and holds the registered over/win levels until the next start pulse.
module life_tracker #(
  parameter int LIVES        = 3,
  parameter int GRACE_CYCLES = 25000000,
  parameter int WIN_SCORE    = 10,
  parameter int SCORE_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               hit,
  input  logic               score_hit,
  output logic               over,
  output logic               win,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic               grace
);

  localparam int CNT_W = (GRACE_CYCLES > 1) ? $clog2(GRACE_CYCLES) : 1;
  localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   GRACE_LOAD = CNT_W'(GRACE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    GRACE = 3'd2,
    LOST  = 3'd3,
    WON   = 3'd4
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [2:0]         lives_next;
  logic [SCORE_W-1:0] score_next, score_inc;
  logic               over_next, win_next, grace_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      lives <= LIVES_INIT;
      score <= '0;
      over  <= 1'b0;
      win   <= 1'b0;
      grace <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      lives <= lives_next;
      score <= score_next;
      over  <= over_next;
      win   <= win_next;
      grace <= grace_next;
    end
  end

  assign score_inc = score + 1'b1;

  // A hit is resolved before a simultaneous score_hit; reaching the win
  // score overrides entry into the grace window.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    lives_next = lives;
    score_next = score;
    case (state)
      IDLE, LOST, WON: begin
        if (start) begin
          state_next = PLAY;
          cnt_next   = '0;
          lives_next = LIVES_INIT;
          score_next = '0;
        end
      end
      PLAY: begin
        if (hit && lives <= 3'd1) begin
          state_next = LOST;
          lives_next = 3'd0;
        end else begin
          if (hit) begin
            state_next = GRACE;
            lives_next = lives - 3'd1;
            cnt_next   = GRACE_LOAD;
          end
          if (score_hit) begin
            score_next = score_inc;
            if (score_inc == WIN_VAL) begin
              state_next = WON;
              cnt_next   = '0;
            end
          end
        end
      end
      GRACE: begin
        if (cnt == '0) begin
          state_next = PLAY;
        end else begin
          cnt_next = cnt - 1'b1;
        end
        if (score_hit) begin
          score_next = score_inc;
          if (score_inc == WIN_VAL) begin
            state_next = WON;
            cnt_next   = '0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        lives_next = LIVES_INIT;
        score_next = '0;
      end
    endcase
  end

  // Level outputs follow the state being entered so they update on the same edge.
  always_comb begin
    over_next  = (state_next == LOST);
    win_next   = (state_next == WON);
    grace_next = (state_next == GRACE);
  end

endmodule

// File: tb/tb_life_tracker.sv
// Randomized and directed bench for life_tracker with a scoreboard fed by an
// abstract game model (flags and counters, not the RTL state machine).
module tb_life_tracker;

  localparam int LIVES = 3;
  localparam int GRACE_CYCLES = 4;
  localparam int WIN_SCORE = 5;
  localparam int SCORE_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic hit = 1'b0;
  logic score_hit = 1'b0;
  logic over, win, grace;
  logic [2:0] lives;
  logic [SCORE_W-1:0] score;

  typedef struct packed {
    logic               over;
    logic               win;
    logic [2:0]         lives;
    logic [SCORE_W-1:0] score;
    logic               grace;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: game phase flags plus remaining-grace cycle count.
  bit m_playing, m_lost, m_won;
  int m_lives, m_score, m_grace_left;

  life_tracker #(
    .LIVES(LIVES), .GRACE_CYCLES(GRACE_CYCLES),
    .WIN_SCORE(WIN_SCORE), .SCORE_W(SCORE_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hit(hit), .score_hit(score_hit),
    .over(over), .win(win), .lives(lives), .score(score), .grace(grace)
  );

  always #5 clk = ~clk;

  function automatic exp_t model_out();
    exp_t e;
    e.over  = m_lost;
    e.win   = m_won;
    e.lives = 3'(m_lives);
    e.score = SCORE_W'(m_score);
    e.grace = (m_grace_left > 0);
    return e;
  endfunction

  task automatic model_reset();
    m_playing = 0; m_lost = 0; m_won = 0;
    m_lives = LIVES; m_score = 0; m_grace_left = 0;
  endtask

  task automatic model_step(input bit s, input bit h, input bit sh);
    if (!m_playing) begin
      if (s) begin
        m_playing = 1; m_lost = 0; m_won = 0;
        m_lives = LIVES; m_score = 0; m_grace_left = 0;
      end
    end else begin
      if (m_grace_left > 0) m_grace_left--;
      else if (h) begin
        if (m_lives == 1) begin
          m_lives = 0; m_lost = 1; m_playing = 0;
        end else begin
          m_lives--; m_grace_left = GRACE_CYCLES;
        end
      end
      if (m_playing && sh) begin
        m_score++;
        if (m_score == WIN_SCORE) begin
          m_won = 1; m_playing = 0; m_grace_left = 0;
        end
      end
    end
  endtask

  task automatic checkOutput(input string name, input exp_t e);
    exp_t a;
    a = '{over: over, win: win, lives: lives, score: score, grace: grace};
    checks++;
    if (a !== e) begin
      errors++;
      $display("[TB] FAIL %s t=%0t: got over=%b win=%b lives=%0d score=%0d grace=%b, expected over=%b win=%b lives=%0d score=%0d grace=%b",
               name, $time, a.over, a.win, a.lives, a.score, a.grace,
               e.over, e.win, e.lives, e.score, e.grace);
    end
  endtask

  // One clock of stimulus; the expectation for the next edge goes to the scoreboard.
  task automatic applyStimulus(input bit s, input bit h, input bit sh);
    @(posedge clk);
    #2;
    start = s; hit = h; score_hit = sh;
    model_step(s, h, sh);
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    start = 0; hit = 0; score_hit = 0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checkOutput("async_reset", model_out());
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: DUT outputs are valid every cycle, compared just after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("scoreboard", e);
      end
    end
  end

  initial begin
    model_reset();
    #13;
    checkOutput("power_on_reset", model_out());
    @(negedge clk);
    rst_n = 1'b1;

    // Hits are ignored in IDLE, then start enters play.
    applyStimulus(0, 1, 1);
    applyStimulus(1, 0, 0);

    // Grace window, a hit inside it, then a counted hit after it.
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 0);
    idle(4);
    applyStimulus(0, 1, 0);
    idle(5);
    applyStimulus(0, 1, 0);

    // Lost is held while hit/score_hit toggle, then restart.
    for (int i = 0; i < 1000; i++)
      applyStimulus(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    applyStimulus(1, 0, 0);

    // Score to the win with one point scored during grace, then saturate.
    applyStimulus(0, 0, 1);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 1);
    idle(5);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);

    // Fatal hit together with score_hit: lost, score unchanged.
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 1, 0);
    idle(5);
    applyStimulus(0, 1, 0);
    idle(5);
    applyStimulus(0, 1, 1);

    // Non-fatal hit together with the winning score_hit.
    applyStimulus(1, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1);
    applyStimulus(0, 1, 1);

    // Async reset during grace with lives=1, score=3; hit in IDLE does nothing.
    applyStimulus(1, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1);
    applyStimulus(0, 1, 0);
    idle(5);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);
    async_reset();
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 0);

    // Randomized play.
    for (int i = 0; i < 3000; i++)
      applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 4) == 0));

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/life_tracker.md
Name: life_tracker

Overview:
- Game-state controller that produces the `over` level consumed by the LED game-over indicator stage. It sits between collision detection and the LED/display outputs.
- Counts player hits against a life budget and enforces an invulnerability (grace) window after each hit.
- Counts target hits towards a win score, and asserts `over` (lost) or `win` as a held level until restart.

Parameters:
- LIVES, 3, lives loaded at reset and restart (1..7)
- GRACE_CYCLES, 25000000, invulnerability length in clk cycles after a non-fatal hit (0.5 s at 50 MHz; >=1)
- WIN_SCORE, 10, score value that ends the game as a win (1..2^SCORE_W-1)
- SCORE_W, 8, score counter width

Ports:
- clk  input  1  system clock (50 MHz)
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle restart/start pulse, synchronous to clk, already debounced upstream
- hit  input  1  one-cycle pulse: player struck by enemy shot
- score_hit  input  1  one-cycle pulse: player shot struck a target
- over  output  1  high while the game is lost; feeds the LED indicator `over` input
- win  output  1  high while the game is won
- lives  output  3  remaining lives
- score  output  SCORE_W  current score
- grace  output  1  high during the invulnerability window

Behaviour:
- Registers and reset:
  - All outputs are registered.
  - Asynchronous reset (rst_n=0) forces: state=IDLE, lives=LIVES, score=0, over=0, win=0, grace=0, grace counter=0.
  - Reset asserted mid-game behaves identically, with no residual state.
- States: IDLE, PLAY, GRACE, LOST, WON. Every transition takes effect on the clk edge where its input is sampled, and outputs reflect the new state on that same edge (1-cycle latency from input pulse to output).
- IDLE:
  - hit and score_hit are ignored.
  - start -> PLAY, with lives=LIVES and score=0.
- PLAY:
  - hit with lives>1: lives-=1, grace counter=GRACE_CYCLES-1, -> GRACE, grace=1.
  - hit with lives==1: lives=0, -> LOST, over=1.
  - score_hit: score+=1. If the new score equals WIN_SCORE: -> WON, win=1.
  - hit and score_hit in the same cycle: the hit is evaluated first.
    - If the hit is fatal, score is NOT incremented and the state goes to LOST.
    - Otherwise both take effect. If the score also reaches WIN_SCORE, WON takes priority over GRACE, lives are still decremented, and grace stays 0.
  - start is ignored.
- GRACE:
  - hit is ignored (lives unchanged).
  - score_hit is counted as in PLAY, including the transition to WON, which clears grace.
  - The grace counter decrements each cycle. When the counter is 0 the next edge returns to PLAY with grace=0.
  - grace is therefore high for exactly GRACE_CYCLES cycles.
  - start is ignored.
- LOST:
  - over=1 is held indefinitely; lives=0 and score are frozen.
  - hit and score_hit are ignored.
  - start -> PLAY, with lives=LIVES, score=0, over=0 on the same edge.
- WON:
  - win=1 is held; score and lives are frozen.
  - hit and score_hit are ignored.
  - start -> PLAY with the same reload; win=0.
- Arithmetic and exclusivity:
  - score never exceeds WIN_SCORE, so there is no wrap-around.
  - lives never underflows below 0.
  - over and win are never high simultaneously.
- Unreachable state encodings recover to IDLE on the next edge.

Test Plan (LIVES=3, GRACE_CYCLES=4, WIN_SCORE=5):
- Reset, then start pulse -> next edge: lives=3, score=0, over=0, win=0, grace=0, state PLAY.
- Hit in PLAY -> lives=2, grace=1 for exactly 4 cycles. A second hit at grace cycle 2 leaves lives=2. After grace drops, another hit -> lives=1.
- Three spaced hits (each after grace expires) -> after the third, lives=0 and over=1. Over stays 1 for 1000 cycles with hit and score_hit toggling. Then start -> over=0, lives=3, score=0.
- Five score_hit pulses, with one of them during grace -> score counts 1..5, then win=1, grace=0, over=0. Further score_hit leaves score=5.
- With lives=1, hit and score_hit in the same cycle -> over=1, score unchanged. With lives=3, score=4, hit and score_hit together -> win=1, lives=2, grace=0.
- rst_n pulsed low asynchronously between clk edges during GRACE with lives=1, score=3 -> outputs immediately go to lives=3, score=0, grace=0, over=0, IDLE. A hit before the next start has no effect.
